alarm_ctrl: RTL and testbench

- Mode/sequencing controller for the alarm-clock counter chain.
- Prescales the 50 MHz clock into a one-cycle seconds enable for the first stage of the BCD divider cascade.
- Steers the user buttons into time-set increments or alarm-register edits, stores the alarm time, and runs the alarm, snooze and timeout state machine that drives the buzzer.

---
 rtl/alarm_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm-clock mode/sequencing controller: seconds prescaler, time/alarm set steering,
// alarm register storage and the alarm/snooze/timeout state machine driving the buzzer.
`timescale 1ns/1ps

module alarm_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SNOOZE_SEC    = 300,
  parameter int ALARM_TO_SEC  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       snooze_btn,
  input  logic       alm_on,
  input  logic [7:0] cur_hr,
  input  logic [7:0] cur_min,
  input  logic       cur_sec_zero,
  output logic       sec_en,
  output logic       hr_inc,
  output logic       min_inc,
  output logic [7:0] alm_hr,
  output logic [7:0] alm_min,
  output logic       buzz,
  output logic [2:0] state
);

  localparam logic [2:0] ST_RUN         = 3'd0;
  localparam logic [2:0] ST_SET_HR      = 3'd1;
  localparam logic [2:0] ST_SET_MIN     = 3'd2;
  localparam logic [2:0] ST_SET_ALM_HR  = 3'd3;
  localparam logic [2:0] ST_SET_ALM_MIN = 3'd4;
  localparam logic [2:0] ST_ALARM       = 3'd5;
  localparam logic [2:0] ST_SNOOZE      = 3'd6;

  localparam int MAX_SEC = (SNOOZE_SEC > ALARM_TO_SEC) ? SNOOZE_SEC : ALARM_TO_SEC;
  localparam int SEC_W   = $clog2(MAX_SEC + 1);
  localparam int PRE_W   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
  localparam logic [SEC_W-1:0] ALARM_LAST  = SEC_W'(ALARM_TO_SEC - 1);

  logic [2:0]       r_state;
  logic [PRE_W-1:0] r_presc;
  logic [SEC_W-1:0] r_sec_cnt;
  logic             r_match_d;
  logic [7:0]       r_alm_hr;
  logic [7:0]       r_alm_min;
  logic             r_hr_inc;
  logic             r_min_inc;
  logic             r_buzz;

  logic [2:0]       w_state_next;
  logic [PRE_W-1:0] w_presc_next;
  logic [SEC_W-1:0] w_sec_cnt_next;
  logic [SEC_W-1:0] w_sec_last;
  logic [7:0]       w_alm_hr_next;
  logic [7:0]       w_alm_min_next;
  logic             w_hr_inc_next;
  logic             w_min_inc_next;
  logic             w_time_frozen;
  logic             w_sec_en;
  logic             w_match;
  logic             w_rise;
  logic             w_timed_state;
  logic             w_expire;

  // BCD increment of a {tens,units} byte with wrap from `top` back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [7:0] res;
    if (v == top) begin
      res = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      res = {v[7:4] + 4'd1, 4'd0};
    end else begin
      res = {v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Time is frozen while the clock itself is being set.
  assign w_time_frozen = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
  assign w_sec_en      = (r_presc == PRE_LAST) && !w_time_frozen;

  always_comb begin
    w_presc_next = r_presc + PRE_W'(1);
    if (w_time_frozen || (r_presc == PRE_LAST)) begin
      w_presc_next = '0;
    end
  end

  assign w_match = alm_on && (cur_hr == r_alm_hr) && (cur_min == r_alm_min) && cur_sec_zero;
  assign w_rise  = w_match && !r_match_d;

  assign w_timed_state = (r_state == ST_ALARM) || (r_state == ST_SNOOZE);
  assign w_sec_last    = (r_state == ST_ALARM) ? ALARM_LAST : SNOOZE_LAST;
  assign w_expire      = w_timed_state && w_sec_en && (r_sec_cnt == w_sec_last);

  always_comb begin
    w_state_next   = r_state;
    w_hr_inc_next  = 1'b0;
    w_min_inc_next = 1'b0;
    w_alm_hr_next  = r_alm_hr;
    w_alm_min_next = r_alm_min;
    case (r_state)
      ST_RUN: begin
        if (mode_btn) begin
          w_state_next = ST_SET_HR;
        end else if (w_rise) begin
          w_state_next = ST_ALARM;
        end
      end
      ST_SET_HR: begin
        if (mode_btn) begin
          w_state_next = ST_SET_MIN;
        end else if (inc_btn) begin
          w_hr_inc_next = 1'b1;
        end
      end
      ST_SET_MIN: begin
        if (mode_btn) begin
          w_state_next = ST_SET_ALM_HR;
        end else if (inc_btn) begin
          w_min_inc_next = 1'b1;
        end
      end
      ST_SET_ALM_HR: begin
        if (mode_btn) begin
          w_state_next = ST_SET_ALM_MIN;
        end else if (inc_btn) begin
          w_alm_hr_next = bcd_inc(r_alm_hr, 8'h23);
        end
      end
      ST_SET_ALM_MIN: begin
        if (mode_btn) begin
          w_state_next = ST_RUN;
        end else if (inc_btn) begin
          w_alm_min_next = bcd_inc(r_alm_min, 8'h59);
        end
      end
      ST_ALARM: begin
        if (!alm_on || mode_btn) begin
          w_state_next = ST_RUN;
        end else if (snooze_btn) begin
          w_state_next = ST_SNOOZE;
        end else if (w_expire) begin
          w_state_next = ST_RUN;
        end
      end
      ST_SNOOZE: begin
        if (!alm_on || mode_btn) begin
          w_state_next = ST_RUN;
        end else if (w_expire) begin
          w_state_next = ST_ALARM;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Any state change restarts the second counter, so ALARM/SNOOZE always begin at zero.
  always_comb begin
    w_sec_cnt_next = r_sec_cnt;
    if (w_state_next != r_state) begin
      w_sec_cnt_next = '0;
    end else if (w_timed_state && w_sec_en) begin
      w_sec_cnt_next = r_sec_cnt + SEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_presc   <= '0;
      r_sec_cnt <= '0;
      r_match_d <= 1'b0;
      r_alm_hr  <= 8'h00;
      r_alm_min <= 8'h00;
      r_hr_inc  <= 1'b0;
      r_min_inc <= 1'b0;
      r_buzz    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_sec_cnt <= w_sec_cnt_next;
      r_match_d <= w_match;
      r_alm_hr  <= w_alm_hr_next;
      r_alm_min <= w_alm_min_next;
      r_hr_inc  <= w_hr_inc_next;
      r_min_inc <= w_min_inc_next;
      r_buzz    <= (w_state_next == ST_ALARM);
    end
  end

  assign sec_en  = w_sec_en;
  assign hr_inc  = r_hr_inc;
  assign min_inc = r_min_inc;
  assign alm_hr  = r_alm_hr;
  assign alm_min = r_alm_min;
  assign buzz    = r_buzz;
  assign state   = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random buttons, scored against an
// integer-level model of the alarm clock through an expected-output queue.
`timescale 1ns/1ps

module tb_alarm_ctrl;

  localparam int T  = 4;
  localparam int SN = 2;
  localparam int TO = 3;

  logic       clk;
  logic       rst_n;
  logic       mode_btn, inc_btn, snooze_btn, alm_on, cur_sec_zero;
  logic [7:0] cur_hr, cur_min;
  logic       sec_en, hr_inc, min_inc, buzz;
  logic [7:0] alm_hr, alm_min;
  logic [2:0] state;

  alarm_ctrl #(.TICKS_PER_SEC(T), .SNOOZE_SEC(SN), .ALARM_TO_SEC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .snooze_btn(snooze_btn), .alm_on(alm_on), .cur_hr(cur_hr), .cur_min(cur_min),
    .cur_sec_zero(cur_sec_zero), .sec_en(sec_en), .hr_inc(hr_inc), .min_inc(min_inc),
    .alm_hr(alm_hr), .alm_min(alm_min), .buzz(buzz), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       bz;
    logic       se;
    logic       hi;
    logic       mi;
    logic [7:0] ah;
    logic [7:0] am;
  } snap_t;

  snap_t sb_q[$];
  snap_t mon_exp;
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: modes by number, alarm time as plain hours/minutes, seconds-left countdown.
  int m_mode, m_tick, m_left, m_ah, m_am;
  bit m_match_prev, m_buzz, m_hi, m_mi;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tick = 0; m_left = 0; m_ah = 0; m_am = 0;
    m_match_prev = 0; m_buzz = 0; m_hi = 0; m_mi = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 3'(m_mode);
    s.bz = m_buzz;
    s.se = (m_tick == T - 1) && (m_mode != 1) && (m_mode != 2);
    s.hi = m_hi;
    s.mi = m_mi;
    s.ah = to_bcd(m_ah);
    s.am = to_bcd(m_am);
    return s;
  endfunction

  task automatic model_advance();
    bit sec_now, match, rise;
    int nm;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sec_now = (m_tick == T - 1) && (m_mode != 1) && (m_mode != 2);
    match = alm_on && (cur_hr == to_bcd(m_ah)) && (cur_min == to_bcd(m_am)) && cur_sec_zero;
    rise = match && !m_match_prev;
    nm = m_mode;
    m_hi = 0;
    m_mi = 0;
    case (m_mode)
      0: if (mode_btn) nm = 1; else if (rise) nm = 5;
      1: if (mode_btn) nm = 2; else if (inc_btn) m_hi = 1;
      2: if (mode_btn) nm = 3; else if (inc_btn) m_mi = 1;
      3: if (mode_btn) nm = 4; else if (inc_btn) m_ah = (m_ah + 1) % 24;
      4: if (mode_btn) nm = 0; else if (inc_btn) m_am = (m_am + 1) % 60;
      5: begin
        if (!alm_on || mode_btn) nm = 0;
        else if (snooze_btn) nm = 6;
        else if (sec_now) begin
          if (m_left == 1) nm = 0; else m_left = m_left - 1;
        end
      end
      6: begin
        if (!alm_on || mode_btn) nm = 0;
        else if (sec_now) begin
          if (m_left == 1) nm = 5; else m_left = m_left - 1;
        end
      end
      default: nm = 0;
    endcase
    if (nm != m_mode && nm == 5) m_left = TO;
    if (nm != m_mode && nm == 6) m_left = SN;
    m_tick = (m_mode == 1 || m_mode == 2 || m_tick == T - 1) ? 0 : m_tick + 1;
    m_match_prev = match;
    m_mode = nm;
    m_buzz = (nm == 5);
  endtask

  // One clock of stimulus: inputs held across the edge, expectation queued after it.
  task automatic tick(input bit mb, input bit ib, input bit sb);
    mode_btn = mb;
    inc_btn = ib;
    snooze_btn = sb;
    if (mb || ib || sb)
      $display("cyc=%0d press mode=%0d inc=%0d snooze=%0d model_state=%0d", cyc, mb, ib, sb, m_mode);
    @(posedge clk);
    model_advance();
    sb_q.push_back(model_snap());
    #1;
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    snooze_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    $display("cyc=%0d async reset asserted between edges", cyc);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_buzz", 32'(buzz), 0);
    check("rst_alm_hr", 32'(alm_hr), 0);
    check("rst_alm_min", 32'(alm_min), 0);
    idle(2);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_exp = sb_q.pop_front();
      check("state", 32'(state), 32'(mon_exp.st));
      check("buzz", 32'(buzz), 32'(mon_exp.bz));
      check("sec_en", 32'(sec_en), 32'(mon_exp.se));
      check("hr_inc", 32'(hr_inc), 32'(mon_exp.hi));
      check("min_inc", 32'(min_inc), 32'(mon_exp.mi));
      check("alm_hr", 32'(alm_hr), 32'(mon_exp.ah));
      check("alm_min", 32'(alm_min), 32'(mon_exp.am));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mode_btn = 0; inc_btn = 0; snooze_btn = 0;
    alm_on = 0; cur_hr = 8'h00; cur_min = 8'h00; cur_sec_zero = 0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(20);

    // Clock time set: hours then minutes.
    tick(1, 0, 0);
    for (int k = 0; k < 3; k++) begin tick(0, 1, 0); tick(0, 0, 0); end
    check("set_hr_state", 32'(state), 1);
    tick(1, 0, 0);
    tick(0, 1, 0);
    idle(2);

    // Alarm register wrap: 25 hour presses, 61 minute presses.
    tick(1, 0, 0);
    for (int k = 0; k < 25; k++) tick(0, 1, 0);
    @(negedge clk);
    check("alm_hr_wrap", 32'(alm_hr), 32'h01);
    tick(1, 0, 0);
    for (int k = 0; k < 61; k++) tick(0, 1, 0);
    @(negedge clk);
    check("alm_min_wrap", 32'(alm_min), 32'h01);
    tick(1, 0, 0);

    // Program alarm to 07:30.
    for (int k = 0; k < 3; k++) tick(1, 0, 0);
    for (int k = 0; k < 6; k++) tick(0, 1, 0);
    tick(1, 0, 0);
    for (int k = 0; k < 29; k++) tick(0, 1, 0);
    tick(1, 0, 0);
    @(negedge clk);
    check("alm_0730_hr", 32'(alm_hr), 32'h07);
    check("alm_0730_min", 32'(alm_min), 32'h30);

    // Trigger and automatic timeout, no retrigger while seconds still read 00.
    alm_on = 1; cur_hr = 8'h07; cur_min = 8'h30; cur_sec_zero = 0;
    tick(0, 0, 0);
    cur_sec_zero = 1;
    tick(0, 0, 0);
    check("trig_state", 32'(state), 5);
    check("trig_buzz", 32'(buzz), 1);
    idle(16);
    check("timeout_state", 32'(state), 0);
    check("timeout_buzz", 32'(buzz), 0);

    // Snooze loop, then snooze+mode together dismisses.
    cur_sec_zero = 0; tick(0, 0, 0);
    cur_sec_zero = 1; tick(0, 0, 0);
    tick(0, 0, 1);
    check("snooze_state", 32'(state), 6);
    check("snooze_buzz", 32'(buzz), 0);
    idle(9);
    check("realarm_state", 32'(state), 5);
    check("realarm_buzz", 32'(buzz), 1);
    tick(1, 0, 1);
    check("dismiss_state", 32'(state), 0);

    // alm_on override from SNOOZE, then reset mid-ALARM.
    cur_sec_zero = 0; tick(0, 0, 0);
    cur_sec_zero = 1; tick(0, 0, 0);
    tick(0, 0, 1);
    alm_on = 0; tick(0, 0, 0);
    check("almoff_state", 32'(state), 0);
    alm_on = 1; tick(0, 0, 0);
    check("rearm_state", 32'(state), 5);
    idle(2);
    async_reset();
    idle(3);

    // Random operation.
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) async_reset();
      alm_on = ($urandom_range(0, 31) != 0);
      cur_hr = ($urandom_range(0, 1) != 0) ? to_bcd(m_ah) : to_bcd(int'($urandom_range(0, 23)));
      cur_min = ($urandom_range(0, 1) != 0) ? to_bcd(m_am) : to_bcd(int'($urandom_range(0, 59)));
      cur_sec_zero = ($urandom_range(0, 2) == 0);
      tick($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
